// File: rtl/cnn_layer1_pix_feeder.sv
// cnn_layer1_pix_feeder: holds one binary image written row-by-row by the host.
// On START it streams the image in raster order to the layer-1 channel, then
// raises SQUEEZE until the channel reports its conv last pixel. A watchdog
// aborts the squeeze phase if that report never arrives.
module cnn_layer1_pix_feeder #(
    parameter int P_WIDTH  = 64,
    parameter int P_HEIGHT = 64,
    parameter int P_WCNT_W = 6,
    parameter int P_HCNT_W = 6,
    parameter int P_GAP    = 0,
    parameter int P_TO_W   = 16
) (
    input  logic                CLK,
    input  logic                RSTn,
    input  logic                WR_EN,
    input  logic [P_HCNT_W-1:0] WR_ROW,
    input  logic [P_WIDTH-1:0]  WR_DATA,
    input  logic                START,
    output logic                DIN_VALID,
    output logic                DIN,
    output logic                SQUEEZE,
    input  logic                CONV_LAST_PIX,
    output logic                BUSY,
    output logic                DONE,
    output logic                TIMEOUT
);

    localparam int GAP_W = (P_GAP > 1) ? $clog2(P_GAP) : 1;
    localparam logic [GAP_W-1:0]    GAP_LAST = GAP_W'((P_GAP > 0) ? P_GAP - 1 : 0);
    localparam logic [P_WCNT_W-1:0] COL_LAST = P_WCNT_W'(P_WIDTH - 1);
    localparam logic [P_HCNT_W-1:0] ROW_LAST = P_HCNT_W'(P_HEIGHT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STREAM,
        S_GAP,
        S_FLUSH,
        S_FIN
    } state_t;

    state_t              state_q, state_d;
    logic [P_HCNT_W-1:0] row_q, row_d;
    logic [P_WCNT_W-1:0] col_q, col_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [P_TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic                din_valid_q, din_valid_d;
    logic                din_q, din_d;
    logic                squeeze_q, squeeze_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                timeout_q, timeout_d;

    logic [P_WIDTH-1:0]  mem_q [P_HEIGHT];
    logic                mem_we;

    // Host writes land only while idle and only for rows that exist.
    always_comb begin
        mem_we = WR_EN && (state_q == S_IDLE) && (int'(WR_ROW) < P_HEIGHT);
    end

    // Image storage; deliberately not reset so a frame can be replayed after an abort.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem_q[WR_ROW] <= WR_DATA;
        end
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        gap_d       = gap_q;
        to_cnt_d    = to_cnt_q;
        din_valid_d = 1'b0;
        din_d       = 1'b0;
        squeeze_d   = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        timeout_d   = timeout_q;
        unique case (state_q)
            S_IDLE: begin
                if (START) begin
                    state_d   = S_STREAM;
                    row_d     = '0;
                    col_d     = '0;
                    gap_d     = '0;
                    to_cnt_d  = '0;
                    timeout_d = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            S_STREAM: begin
                din_valid_d = 1'b1;
                din_d       = mem_q[row_q][col_q];
                if (col_q == COL_LAST) begin
                    col_d = '0;
                    row_d = row_q + P_HCNT_W'(1);
                end else begin
                    col_d = col_q + P_WCNT_W'(1);
                end
                if ((col_q == COL_LAST) && (row_q == ROW_LAST)) begin
                    state_d = S_FLUSH;
                end else if (P_GAP > 0) begin
                    gap_d   = '0;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = S_STREAM;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            S_FLUSH: begin
                if (CONV_LAST_PIX) begin
                    state_d = S_FIN;
                end else if (to_cnt_q == '1) begin
                    timeout_d = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = S_IDLE;
                end else begin
                    squeeze_d = 1'b1;
                    to_cnt_d  = to_cnt_q + P_TO_W'(1);
                end
            end
            S_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control state and registered outputs with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q     <= S_IDLE;
            row_q       <= '0;
            col_q       <= '0;
            gap_q       <= '0;
            to_cnt_q    <= '0;
            din_valid_q <= 1'b0;
            din_q       <= 1'b0;
            squeeze_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            gap_q       <= gap_d;
            to_cnt_q    <= to_cnt_d;
            din_valid_q <= din_valid_d;
            din_q       <= din_d;
            squeeze_q   <= squeeze_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
        end
    end

    always_comb begin
        DIN_VALID = din_valid_q;
        DIN       = din_q;
        SQUEEZE   = squeeze_q;
        BUSY      = busy_q;
        DONE      = done_q;
        TIMEOUT   = timeout_q;
    end

endmodule

// File: tb/tb_cnn_layer1_pix_feeder.sv
// Bench for cnn_layer1_pix_feeder: one gapless instance with a long watchdog and
// one gapped instance with a short watchdog. Expected pixels are queued from a
// bench-side image model when a frame starts and popped as valids appear.
module tb_cnn_layer1_pix_feeder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn, wr_en0, wr_en1, start0, start1, clp0, clp1;
    logic [5:0]  wr_row;
    logic [63:0] wr_data;
    logic        dv0, din0, sq0, busy0, done0, to0;
    logic        dv1, din1, sq1, busy1, done1, to1;

    cnn_layer1_pix_feeder #(.P_GAP(0), .P_TO_W(16)) dut0 (
        .CLK(clk), .RSTn(rstn), .WR_EN(wr_en0), .WR_ROW(wr_row), .WR_DATA(wr_data),
        .START(start0), .DIN_VALID(dv0), .DIN(din0), .SQUEEZE(sq0),
        .CONV_LAST_PIX(clp0), .BUSY(busy0), .DONE(done0), .TIMEOUT(to0)
    );

    cnn_layer1_pix_feeder #(.P_GAP(2), .P_TO_W(4)) dut1 (
        .CLK(clk), .RSTn(rstn), .WR_EN(wr_en1), .WR_ROW(wr_row), .WR_DATA(wr_data),
        .START(start1), .DIN_VALID(dv1), .DIN(din1), .SQUEEZE(sq1),
        .CONV_LAST_PIX(clp1), .BUSY(busy1), .DONE(done1), .TIMEOUT(to1)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [63:0] img [2][64];
    bit          sbq0[$];
    bit          sbq1[$];
    int          vcnt[2], first_v[2], last_v[2], badspace[2];
    int          sq_rise[2], sq_fall[2], done_cnt[2], done_cyc[2];
    logic        sq_prev[2], busy_prev[2], done_busy[2], done_busy_prev[2];

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic clear(input int i);
        vcnt[i]      = 0;
        first_v[i]   = -1;
        last_v[i]    = -1;
        badspace[i]  = 0;
        sq_rise[i]   = -1;
        sq_fall[i]   = -1;
        done_cnt[i]  = 0;
        done_cyc[i]  = -1;
        sq_prev[i]   = 1'b0;
        busy_prev[i] = 1'b0;
    endtask

    // Observe one instance's outputs at the falling edge.
    task automatic mon(input int i, input logic dv, input logic d, input logic sq,
                       input logic dn, input logic bz);
        bit e;
        if (dv) begin
            if (i == 0 && sbq0.size() > 0) begin
                e = sbq0.pop_front();
                check("dut0_din", d, e);
            end else if (i == 1 && sbq1.size() > 0) begin
                e = sbq1.pop_front();
                check("dut1_din", d, e);
            end else begin
                check("unexpected_pixel", dv, 0);
            end
            if (vcnt[i] == 0) first_v[i] = cyc;
            else if (cyc - last_v[i] != ((i == 0) ? 1 : 3)) badspace[i]++;
            last_v[i] = cyc;
            vcnt[i]++;
        end
        if (sq && !sq_prev[i]) sq_rise[i] = cyc;
        if (!sq && sq_prev[i]) sq_fall[i] = cyc;
        if (dn) begin
            done_cnt[i]++;
            done_cyc[i]       = cyc;
            done_busy[i]      = bz;
            done_busy_prev[i] = busy_prev[i];
        end
        sq_prev[i]   = sq;
        busy_prev[i] = bz;
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        mon(0, dv0, din0, sq0, done0, busy0);
        mon(1, dv1, din1, sq1, done1, busy1);
    endtask

    task automatic push_frame(input int i);
        for (int r = 0; r < 64; r++) begin
            for (int c = 0; c < 64; c++) begin
                if (i == 0) sbq0.push_back(img[0][r][c]);
                else        sbq1.push_back(img[1][r][c]);
            end
        end
    endtask

    task automatic pulse_start(input int i, output int k);
        if (i == 0) start0 = 1'b1;
        else        start1 = 1'b1;
        step();
        start0 = 1'b0;
        start1 = 1'b0;
        k = cyc;
    endtask

    task automatic wait_vcnt(input int i, input int n, input int bound);
        int t = 0;
        while (vcnt[i] < n && t < bound) begin
            step();
            t++;
        end
        check("wait_valid_count", vcnt[i] >= n, 1);
    endtask

    task automatic wait_rise(input int i, input int bound);
        int t = 0;
        while (sq_rise[i] < 0 && t < bound) begin
            step();
            t++;
        end
        check("wait_squeeze_rise", sq_rise[i] >= 0, 1);
    endtask

    initial begin
        int k;
        int t;
        rstn = 1'b0; wr_en0 = 1'b0; wr_en1 = 1'b0; wr_row = '0; wr_data = '0;
        start0 = 1'b0; start1 = 1'b0; clp0 = 1'b0; clp1 = 1'b0;
        clear(0);
        clear(1);
        repeat (3) step();
        check("rst_dut0_outs", {dv0, din0, sq0, busy0, done0, to0}, 0);
        check("rst_dut1_outs", {dv1, din1, sq1, busy1, done1, to1}, 0);
        rstn = 1'b1;

        // Checkerboard into both instances.
        for (int r = 0; r < 64; r++) begin
            wr_en0  = 1'b1;
            wr_en1  = 1'b1;
            wr_row  = 6'(r);
            wr_data = (r % 2 == 1) ? 64'hAAAA_AAAA_AAAA_AAAA : 64'h5555_5555_5555_5555;
            img[0][r] = wr_data;
            img[1][r] = wr_data;
            step();
        end
        wr_en0 = 1'b0;
        wr_en1 = 1'b0;

        // Frame A: gapless stream, ignored write + START mid-frame, CLP 37 cycles into flush.
        clear(0);
        push_frame(0);
        pulse_start(0, k);
        check("a_busy_after_start", busy0, 1);
        check("a_no_valid_at_start", dv0, 0);
        wait_vcnt(0, 100, 200);
        wr_en0 = 1'b1; wr_row = '0; wr_data = '1; start0 = 1'b1;
        step();
        wr_en0 = 1'b0; start0 = 1'b0;
        wait_rise(0, 5000);
        check("a_valid_count", vcnt[0], 4096);
        check("a_first_valid", first_v[0], k + 1);
        check("a_last_valid", last_v[0], k + 4096);
        check("a_gapless", badspace[0], 0);
        check("a_squeeze_rise", sq_rise[0], last_v[0] + 1);
        check("a_queue_drained", sbq0.size(), 0);
        repeat (36) step();
        clp0 = 1'b1;
        step();
        clp0 = 1'b0;
        k = cyc;
        repeat (5) step();
        check("a_squeeze_fall", sq_fall[0], k);
        check("a_done_count", done_cnt[0], 1);
        check("a_done_cycle", done_cyc[0], k + 1);
        check("a_busy_falls_with_done", {done_busy_prev[0], done_busy[0]}, 2);
        check("a_no_timeout", to0, 0);

        // Frame B: row 0 rewritten while idle, row 1 written with START, reset at pixel 1000.
        wr_en0 = 1'b1; wr_row = '0; wr_data = '1; img[0][0] = '1;
        step();
        clear(0);
        wr_row = 6'd1; wr_data = 64'h0123_4567_89AB_CDEF; img[0][1] = wr_data;
        push_frame(0);
        pulse_start(0, k);
        wr_en0 = 1'b0;
        wait_vcnt(0, 1000, 1100);
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        check("b_reset_outs", {dv0, din0, sq0, busy0, done0, to0}, 0);
        sbq0.delete();
        repeat (5) step();
        check("b_no_done_after_abort", done_cnt[0], 0);
        check("b_idle_after_abort", {busy0, dv0}, 0);

        // Frame C: replay of the preserved image from pixel (0,0).
        clear(0);
        push_frame(0);
        pulse_start(0, k);
        wait_rise(0, 5000);
        check("c_valid_count", vcnt[0], 4096);
        check("c_first_valid", first_v[0], k + 1);
        check("c_queue_drained", sbq0.size(), 0);
        clp0 = 1'b1;
        step();
        clp0 = 1'b0;
        repeat (3) step();
        check("c_done_count", done_cnt[0], 1);

        // Gapped instance: spacing, frame duration, then squeeze watchdog.
        clear(1);
        push_frame(1);
        pulse_start(1, k);
        wait_rise(1, 13000);
        check("g_valid_count", vcnt[1], 4096);
        check("g_first_valid", first_v[1], k + 1);
        check("g_spacing", badspace[1], 0);
        check("g_last_valid_offset", last_v[1] - k, 12286);
        check("g_squeeze_rise", sq_rise[1], last_v[1] + 1);
        t = 0;
        while (to1 !== 1'b1 && t < 40) begin
            step();
            t++;
        end
        check("t_timeout_set", to1, 1);
        check("t_squeeze_len", sq_fall[1] - sq_rise[1], 15);
        check("t_no_done", done_cnt[1], 0);
        check("t_idle", {busy1, sq1}, 0);
        repeat (4) step();
        check("t_sticky", to1, 1);
        push_frame(1);
        pulse_start(1, k);
        check("t_cleared_by_start", to1, 0);
        check("t_busy_restart", busy1, 1);
        repeat (3) step();
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        sbq1.delete();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
